// File: rtl/mod5_ctrl_arbiter_if.sv
// rtl/mod5_ctrl_arbiter_if.sv - command/response bus between two requesters and mod5_ctrl_arbiter
//
// Signals (bit/slice i belongs to requester i):
//   req_valid[1:0]  command pending
//   req_op[3:0]     [2i+1:2i] opcode: 00 LOAD, 01 UP, 10 DOWN, 11 READ
//   req_arg[5:0]    [3i+2:3i] load value or step count
//   req_ready[1:0]  command accepted this cycle
//   rsp_valid[1:0]  one-cycle completion pulse
//   rsp_data[2:0]   counter value at completion
//   rsp_err         LOAD value out of range
// Modports: master = requester side, slave = arbiter side.

interface mod5_ctrl_arbiter_if;
  logic [1:0] req_valid;
  logic [3:0] req_op;
  logic [5:0] req_arg;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [2:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_arg,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_arg,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mod5_ctrl_arbiter.sv
// rtl/mod5_ctrl_arbiter.sv - two-port arbiter driving an external mod-5 up/down counter
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (shared with the counter)
//   bus       mod5_ctrl_arbiter_if.slave command/response bus
//   cnt_q     current counter value
//   cnt_load  counter load enable (also used to hold the counter)
//   cnt_udi   counter direction, 1 = up
//   cnt_d_in  counter load data
//   busy      high whenever the FSM is not in IDLE
// Build option: define MOD5ARB_FIXED_PRIO_EN for fixed priority (port 0 wins)
// instead of round-robin arbitration.

module mod5_ctrl_arbiter (
  input  logic                clk,
  input  logic                reset_n,
  mod5_ctrl_arbiter_if.slave  bus,
  input  logic [2:0]          cnt_q,
  output logic                cnt_load,
  output logic                cnt_udi,
  output logic [2:0]          cnt_d_in,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  state_t     state;
  state_t     state_nxt;

  logic [1:0] ready_q;
  logic [1:0] rsp_valid_q;
  logic [2:0] rsp_data_q;
  logic       rsp_err_q;

  logic       cmd_port;
  logic [1:0] cmd_op;
  logic [2:0] cmd_arg;
  logic [2:0] steps_left;
  logic       cmd_err;

  logic       grant_port;
  logic       grant_en;
  logic       accepted;
  logic [2:0] cnt_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MOD5ARB_FIXED_PRIO_EN
  always_comb begin
    grant_port = ~bus.req_valid[0];
  end
`else
  logic rr;

  // With a single valid port, that port wins; only contention consults rr.
  always_comb begin
    if (bus.req_valid == 2'b11) begin
      grant_port = rr;
    end else begin
      grant_port = bus.req_valid[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= 1'b0;
    end else if (grant_en) begin
      rr <= ~grant_port;
    end
  end
`endif

  // The grant decision registers req_ready; the ready cycle itself is still
  // IDLE, and the FSM leaves IDLE on the edge that closes the handshake.
  assign grant_en = (state == IDLE) && (ready_q == 2'b00) && (|bus.req_valid);
  assign accepted = (state == IDLE) && (ready_q != 2'b00);
  assign cmd_err  = (cmd_op == OP_LOAD) && (cmd_arg > 3'd4);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b1;
    cnt_udi   = 1'b0;
    cnt_d_in  = cnt_q;

    case (state)
      IDLE: begin
        if (accepted) begin
          if (cmd_op == OP_LOAD) begin
            state_nxt = cmd_err ? RESP : EXEC;
          end else if ((cmd_op == OP_READ) || (cmd_arg == 3'd0)) begin
            state_nxt = RESP;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        if (cmd_op == OP_LOAD) begin
          cnt_d_in  = cmd_arg;
          state_nxt = RESP;
        end else begin
          cnt_load = 1'b0;
          cnt_udi  = (cmd_op == OP_UP);
          if (steps_left == 3'd1) begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Value the counter will hold after this edge; lets the registered
  // rsp_data show the final count during the RESP cycle.
  always_comb begin
    cnt_nxt = cnt_q;
    if (cnt_load) begin
      cnt_nxt = cnt_d_in;
    end else if (cnt_udi) begin
      cnt_nxt = (cnt_q >= 3'd4) ? 3'd0 : cnt_q + 3'd1;
    end else begin
      cnt_nxt = (cnt_q == 3'd0) ? 3'd4 : cnt_q - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command latch, step counter and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 2'b00;
      cmd_port    <= 1'b0;
      cmd_op      <= OP_LOAD;
      cmd_arg     <= 3'd0;
      steps_left  <= 3'd0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 3'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      ready_q <= 2'b00;
      if (grant_en) begin
        ready_q  <= grant_port ? 2'b10 : 2'b01;
        cmd_port <= grant_port;
        cmd_op   <= grant_port ? bus.req_op[3:2]  : bus.req_op[1:0];
        cmd_arg  <= grant_port ? bus.req_arg[5:3] : bus.req_arg[2:0];
      end

      if (accepted) begin
        steps_left <= cmd_arg;
      end else if (state == EXEC) begin
        steps_left <= steps_left - 3'd1;
      end

      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 3'd0;
      rsp_err_q   <= 1'b0;
      if (state_nxt == RESP) begin
        rsp_valid_q <= cmd_port ? 2'b10 : 2'b01;
        rsp_data_q  <= cnt_nxt;
        rsp_err_q   <= cmd_err;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mod5_ctrl_arbiter.sv
// tb/tb_mod5_ctrl_arbiter.sv - directed self-checking bench for mod5_ctrl_arbiter

module tb_mod5_ctrl_arbiter;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

`ifdef MOD5ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] cnt_q;
  logic       cnt_load;
  logic       cnt_udi;
  logic [2:0] cnt_d_in;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  mod5_ctrl_arbiter_if bus ();

  mod5_ctrl_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .cnt_q    (cnt_q),
    .cnt_load (cnt_load),
    .cnt_udi  (cnt_udi),
    .cnt_d_in (cnt_d_in),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Controlled mod-5 counter: advances every clock unless loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 3'd0;
    end else if (cnt_load) begin
      cnt_q <= cnt_d_in;
    end else if (cnt_udi) begin
      cnt_q <= (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
    end else begin
      cnt_q <= (cnt_q == 3'd0) ? 3'd4 : cnt_q - 3'd1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic [1:0] op, input logic [2:0] arg);
    bus.req_valid[port] = 1'b1;
    if (port == 0) begin
      bus.req_op[1:0]  = op;
      bus.req_arg[2:0] = arg;
    end else begin
      bus.req_op[3:2]  = op;
      bus.req_arg[5:3] = arg;
    end
  endtask

  // Drop valid after the handshake edge and scramble the command fields.
  task automatic release_req(input int port);
    @(posedge clk);
    #1;
    bus.req_valid[port] = 1'b0;
    bus.req_op  = 4'hF;
    bus.req_arg = 6'h3F;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;

    reset_n       = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op    = 4'h0;
    bus.req_arg   = 6'h00;
    tick();
    tick();

    // Reset state
    chk("rst_ready",     bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_data",  bus.rsp_data,  3'd0);
    chk("rst_rsp_err",   bus.rsp_err,   1'b0);
    chk("rst_busy",      busy,          1'b0);
    chk("rst_cnt_ctl",   {cnt_load, cnt_udi, cnt_d_in}, {1'b1, 1'b0, 3'd0});
    reset_n = 1'b1;
    tick();

    // Port 0 UP 3 from 0
    drive(0, OP_UP, 3'd3);
    tick();
    chk("up_ready",     bus.req_ready, 2'b01);
    chk("up_ready_hold", {cnt_load, busy}, {1'b1, 1'b0});
    release_req(0);
    tick();
    chk("up_exec1",     {cnt_load, cnt_udi, busy}, {1'b0, 1'b1, 1'b1});
    chk("up_ready_low", bus.req_ready, 2'b00);
    tick();
    tick();
    chk("up_exec3",     {cnt_load, cnt_udi}, {1'b0, 1'b1});
    chk("up_no_rsp",    bus.rsp_valid, 2'b00);
    tick();
    chk("up_rsp",       {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {2'b01, 3'd3, 1'b0});
    chk("up_rsp_hold",  {cnt_load, cnt_d_in, cnt_q}, {1'b1, 3'd3, 3'd3});
    tick();
    chk("up_done",      {bus.rsp_valid, busy}, {2'b00, 1'b0});

    // Port 1 LOAD 1, then DOWN 3: 1 -> 0 -> 4 -> 3
    drive(1, OP_LOAD, 3'd1);
    tick();
    chk("ld1_ready",    bus.req_ready, 2'b10);
    release_req(1);
    tick();
    chk("ld1_exec",     {cnt_load, cnt_d_in}, {1'b1, 3'd1});
    tick();
    chk("ld1_rsp",      {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {2'b10, 3'd1, 1'b0});
    tick();
    drive(1, OP_DOWN, 3'd3);
    tick();
    chk("dn_ready",     bus.req_ready, 2'b10);
    release_req(1);
    tick();
    chk("dn_exec1",     {cnt_load, cnt_udi, cnt_q}, {1'b0, 1'b0, 3'd1});
    tick();
    chk("dn_cnt_a",     cnt_q, 3'd0);
    tick();
    chk("dn_cnt_b",     cnt_q, 3'd4);
    tick();
    chk("dn_rsp",       {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {2'b10, 3'd3, 1'b0});
    tick();

    // Port 0 LOAD 6 (error, counter held), then LOAD 2
    drive(0, OP_LOAD, 3'd6);
    tick();
    chk("lderr_ready",  bus.req_ready, 2'b01);
    release_req(0);
    tick();
    chk("lderr_rsp",    {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {2'b01, 3'd3, 1'b1});
    chk("lderr_hold",   {cnt_load, cnt_d_in, cnt_q}, {1'b1, 3'd3, 3'd3});
    tick();
    chk("lderr_done",   {bus.rsp_valid, bus.rsp_err, busy, cnt_q}, {2'b00, 1'b0, 1'b0, 3'd3});
    drive(0, OP_LOAD, 3'd2);
    tick();
    chk("ld2_ready",    bus.req_ready, 2'b01);
    release_req(0);
    tick();
    chk("ld2_exec",     {cnt_load, cnt_d_in, bus.rsp_valid}, {1'b1, 3'd2, 2'b00});
    tick();
    chk("ld2_rsp",      {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {2'b01, 3'd2, 1'b0});
    tick();

    // Port 1 UP with zero steps: one-cycle latency, counter unchanged
    drive(1, OP_UP, 3'd0);
    tick();
    chk("zs_ready",     bus.req_ready, 2'b10);
    release_req(1);
    tick();
    chk("zs_rsp",       {bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy}, {2'b10, 3'd2, 1'b0, 1'b1});
    tick();

    // Idle with no requests: counter held at 2
    for (int i = 0; i < 10; i++) begin
      chk("idle_hold", {cnt_load, cnt_d_in, cnt_q, busy, bus.req_ready}, {1'b1, 3'd2, 3'd2, 1'b0, 2'b00});
      tick();
    end

    // Both ports READ continuously after reset
    reset_n = 1'b0;
    tick();
    tick();
    bus.req_op    = {OP_READ, OP_READ};
    bus.req_arg   = 6'h00;
    bus.req_valid = 2'b11;
    reset_n       = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_rdy = 2'b00;
      exp_rsp = 2'b00;
      if ((i % 3) == 0) begin
        exp_rdy = (!FIXED_PRIO && ((i / 3) % 2) == 1) ? 2'b10 : 2'b01;
      end
      if ((i % 3) == 1) begin
        exp_rsp = (!FIXED_PRIO && ((i / 3) % 2) == 1) ? 2'b10 : 2'b01;
      end
      chk("rr_ready", bus.req_ready, exp_rdy);
      chk("rr_rsp",   {bus.rsp_valid, bus.rsp_data}, {exp_rsp, 3'd0});
    end
    bus.req_valid = 2'b00;
    tick();

    // Reset during the second EXEC cycle of UP 5
    drive(0, OP_UP, 3'd5);
    tick();
    chk("ab_ready",     bus.req_ready, 2'b01);
    release_req(0);
    tick();
    tick();
    chk("ab_exec2",     {busy, cnt_load, cnt_q}, {1'b1, 1'b0, 3'd1});
    reset_n = 1'b0;
    #1;
    chk("ab_in_reset",  {busy, bus.rsp_valid, cnt_load, cnt_q}, {1'b0, 2'b00, 1'b1, 3'd0});
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_no_rsp", {bus.rsp_valid, busy, bus.req_ready}, {2'b00, 1'b0, 2'b00});
    end
    drive(1, OP_READ, 3'd0);
    tick();
    chk("ab_rd_ready",  bus.req_ready, 2'b10);
    release_req(1);
    tick();
    chk("ab_rd_rsp",    {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {2'b10, 3'd0, 1'b0});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mod5_ctrl_arbiter.md
MOD5_CTRL_ARBITER -- requirements
Module: mod5_ctrl_arbiter

Interface
REQ-001 No parameters; the controlled counter range is fixed at 0..4.
REQ-002 clk  in  1  rising-edge clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-003 reset_n  in  1  async active-low reset, shared with the controlled mod-5 counter.
REQ-004 req_valid  in  2  bit i = requester i has a command pending.
REQ-005 req_op  in  4  [2i+1:2i] = opcode of requester i: 00 LOAD, 01 UP, 10 DOWN, 11 READ.
REQ-006 req_arg  in  6  [3i+2:3i] = load value (LOAD) or step count 0..7 (UP/DOWN); ignored for READ.
REQ-007 req_ready  out  2  bit i = command of requester i accepted this cycle.
REQ-008 rsp_valid  out  2  bit i = one-cycle completion pulse to requester i.
REQ-009 rsp_data  out  3  counter value at completion; valid only while any rsp_valid bit is high.
REQ-010 rsp_err  out  1  qualifies rsp_valid; high when a LOAD value is above 4.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 cnt_q  in  3  current output of the controlled counter.
REQ-013 cnt_load, cnt_udi  out  1 each  load and up/down-select controls to the counter.
REQ-014 cnt_d_in  out  3  load data to the counter.

Function
REQ-015 The counter advances every clock unless loaded, so the block SHALL hold it by driving cnt_load=1 and cnt_d_in=cnt_q in every cycle that is not a step cycle.
REQ-016 States: IDLE, EXEC, RESP. cnt_load, cnt_udi and cnt_d_in SHALL be decoded combinationally from the state and the latched command. rsp_* and req_ready SHALL be registered.
REQ-017 In IDLE, if any req_valid bit is set, the block SHALL grant exactly one requester: it asserts that requester's req_ready for one cycle, latches its op and arg, and leaves IDLE. req_ready SHALL be 0 in EXEC and RESP.
REQ-018 Arbitration: round-robin pointer rr. When both ports are valid, port rr wins. After every grant, rr SHALL point to the port that did not win. A single valid port wins regardless of rr.
REQ-019 LOAD with arg<=4: EXEC for 1 cycle with cnt_load=1 and cnt_d_in=arg, then RESP.
REQ-020 LOAD with arg>4: go directly to RESP with rsp_err=1. No load is issued and the counter is held.
REQ-021 UP/DOWN with arg=N>0: EXEC for exactly N cycles with cnt_load=0 and cnt_udi=1 (UP) or 0 (DOWN), then RESP. The counter wraps 4->0 (UP) and 0->4 (DOWN).
REQ-022 UP/DOWN with arg=0, and READ: go directly from IDLE to RESP.
REQ-023 RESP lasts 1 cycle: rsp_valid[granted]=1, rsp_data=cnt_q (the final value), hold drive per REQ-015. The next state SHALL be IDLE.
REQ-024 Latency from the accept edge to rsp_valid: 1 cycle for READ, zero-step and error commands; 2 cycles for LOAD; N+1 cycles for N steps.
REQ-025 A new grant SHALL NOT occur in the RESP cycle; the earliest back-to-back grant is in the cycle after RESP.
REQ-026 Changes on req_* after acceptance SHALL NOT affect the command in flight.

Reset
REQ-027 While reset_n=0: state=IDLE, rr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, cnt_load=1, cnt_udi=0, cnt_d_in=cnt_q.
REQ-028 Reset asserted mid-EXEC or mid-RESP SHALL abort the command with no response pulse. After release, the block starts in IDLE.

Configuration
REQ-029 Macro MOD5ARB_FIXED_PRIO_EN. When defined, port 0 SHALL always win contention and rr is not implemented. When undefined, round-robin per REQ-018 applies.

Verification
REQ-030 After reset (cnt_q=0), port0 issues UP arg=3 -> ready@T, cnt_load=0/cnt_udi=1 for cycles T+1..T+3, rsp_valid[0]@T+4 with rsp_data=3, rsp_err=0.
REQ-031 cnt_q=1, port1 issues DOWN arg=3 -> counter goes 0, 4, 3; rsp_data=3 at T+4.
REQ-032 port0 issues LOAD arg=6 -> rsp_valid[0]@T+1, rsp_err=1, cnt_q unchanged. Then LOAD arg=2 -> rsp_data=2 at T+2.
REQ-033 Both ports hold valid with READ continuously after reset -> grants alternate 0,1,0,1 every 3 cycles. With MOD5ARB_FIXED_PRIO_EN defined -> port 0 is granted every time.
REQ-034 Reset pulsed during the 2nd EXEC cycle of UP arg=5 -> no rsp_valid, busy=0, state IDLE; the next READ returns 0.
REQ-035 IDLE with no requests for 10 cycles and cnt_q=2 -> cnt_load=1 and cnt_d_in=2 every cycle; cnt_q stays 2.
